// File: rtl/hc4e_prog_loader.sv
// HC4e program memory (256x8, combinational read at pc) with a serial UART loader.
// Define HC4E_LOADER_ECHO_EN to build the ACK/NAK status transmitter on uart_tx.
module hc4e_prog_loader #(
   parameter int unsigned CLK_HZ    = 20_000_000,
   parameter int unsigned BAUD      = 115200,
   parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
   input  logic       clock,
   input  logic       nReset,
   input  logic       uart_rx,
   input  logic [7:0] pc,
   output logic [7:0] instruction,
   output logic       cpu_nReset,
   output logic       loading,
   output logic       load_error,
   output logic       uart_tx
);

   localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam logic [15:0] BitLast      = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HalfLast     = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
   typedef enum logic [2:0] {LdIdle, LdLen, LdData, LdCsum, LdErr} ld_state_e;

   // ---------------------------------------------------------------- receiver
   logic        r_rx_meta, r_rx_sync, r_rx_prev;
   rx_state_e   r_rx_state, w_rx_state_next;
   logic [15:0] r_rx_cnt, w_rx_cnt_next;
   logic [2:0]  r_rx_bit, w_rx_bit_next;
   logic [7:0]  r_rx_shift, w_rx_shift_next;
   logic        r_rx_valid, w_rx_valid_next;
   logic        r_rx_ferr, w_rx_ferr_next;

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         r_rx_meta  <= 1'b1;
         r_rx_sync  <= 1'b1;
         r_rx_prev  <= 1'b1;
         r_rx_state <= RxIdle;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_valid <= 1'b0;
         r_rx_ferr  <= 1'b0;
      end else begin
         r_rx_meta  <= uart_rx;
         r_rx_sync  <= r_rx_meta;
         r_rx_prev  <= r_rx_sync;
         r_rx_state <= w_rx_state_next;
         r_rx_cnt   <= w_rx_cnt_next;
         r_rx_bit   <= w_rx_bit_next;
         r_rx_shift <= w_rx_shift_next;
         r_rx_valid <= w_rx_valid_next;
         r_rx_ferr  <= w_rx_ferr_next;
      end
   end

   always_comb begin
      w_rx_state_next = r_rx_state;
      w_rx_cnt_next   = r_rx_cnt + 16'd1;
      w_rx_bit_next   = r_rx_bit;
      w_rx_shift_next = r_rx_shift;
      w_rx_valid_next = 1'b0;
      w_rx_ferr_next  = 1'b0;
      case (r_rx_state)
         RxIdle: begin
            w_rx_cnt_next = '0;
            if (r_rx_prev && !r_rx_sync) begin
               w_rx_state_next = RxStart;
            end
         end
         RxStart: begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (r_rx_cnt == HalfLast) begin
               w_rx_cnt_next   = '0;
               w_rx_bit_next   = '0;
               w_rx_state_next = r_rx_sync ? RxIdle : RxData;
            end
         end
         RxData: begin
            if (r_rx_cnt == BitLast) begin
               w_rx_cnt_next   = '0;
               w_rx_shift_next = {r_rx_sync, r_rx_shift[7:1]};
               if (r_rx_bit == 3'd7) begin
                  w_rx_state_next = RxStop;
               end else begin
                  w_rx_bit_next = r_rx_bit + 3'd1;
               end
            end
         end
         RxStop: begin
            if (r_rx_cnt == BitLast) begin
               w_rx_cnt_next   = '0;
               w_rx_state_next = RxIdle;
               w_rx_valid_next = r_rx_sync;
               w_rx_ferr_next  = !r_rx_sync;
            end
         end
         default: begin
            w_rx_state_next = RxIdle;
         end
      endcase
   end

   // ------------------------------------------------------------------ loader
   ld_state_e  r_ld_state, w_ld_state_next;
   logic [7:0] r_addr, w_addr_next;
   logic [7:0] r_sum, w_sum_next;
   logic [8:0] r_remain, w_remain_next;
   logic       r_loading, w_loading_next;
   logic       r_load_error, w_load_error_next;
   logic       r_cpu_nreset, w_cpu_nreset_next;
   logic       w_mem_we;
   logic       w_go_len, w_go_err;
   logic       w_sync_hit;

   assign w_sync_hit = r_rx_valid && (r_rx_shift == SYNC_BYTE);

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         r_ld_state   <= LdIdle;
         r_addr       <= '0;
         r_sum        <= '0;
         r_remain     <= '0;
         r_loading    <= 1'b0;
         r_load_error <= 1'b0;
         r_cpu_nreset <= 1'b0;
      end else begin
         r_ld_state   <= w_ld_state_next;
         r_addr       <= w_addr_next;
         r_sum        <= w_sum_next;
         r_remain     <= w_remain_next;
         r_loading    <= w_loading_next;
         r_load_error <= w_load_error_next;
         r_cpu_nreset <= w_cpu_nreset_next;
      end
   end

   always_comb begin
      w_ld_state_next   = r_ld_state;
      w_addr_next       = r_addr;
      w_sum_next        = r_sum;
      w_remain_next     = r_remain;
      w_loading_next    = r_loading;
      w_load_error_next = r_load_error;
      w_cpu_nreset_next = r_cpu_nreset;
      w_mem_we          = 1'b0;
      w_go_len          = 1'b0;
      w_go_err          = 1'b0;
      case (r_ld_state)
         LdIdle: begin
            w_cpu_nreset_next = 1'b1;
            w_go_len          = w_sync_hit;
         end
         LdLen: begin
            if (r_rx_ferr) begin
               w_go_err = 1'b1;
            end else if (r_rx_valid) begin
               // A length byte of zero stands for a full 256-byte image.
               w_remain_next   = (r_rx_shift == 8'd0) ? 9'd256 : {1'b0, r_rx_shift};
               w_addr_next     = '0;
               w_sum_next      = '0;
               w_ld_state_next = LdData;
            end
         end
         LdData: begin
            if (r_rx_ferr) begin
               w_go_err = 1'b1;
            end else if (r_rx_valid) begin
               w_mem_we      = 1'b1;
               w_addr_next   = r_addr + 8'd1;
               w_sum_next    = r_sum + r_rx_shift;
               w_remain_next = r_remain - 9'd1;
               if (r_remain == 9'd1) begin
                  w_ld_state_next = LdCsum;
               end
            end
         end
         LdCsum: begin
            if (r_rx_ferr) begin
               w_go_err = 1'b1;
            end else if (r_rx_valid) begin
               if (r_rx_shift == r_sum) begin
                  w_ld_state_next   = LdIdle;
                  w_loading_next    = 1'b0;
                  w_cpu_nreset_next = 1'b1;
               end else begin
                  w_go_err = 1'b1;
               end
            end
         end
         LdErr: begin
            w_go_len = w_sync_hit;
         end
         default: begin
            w_ld_state_next = LdIdle;
         end
      endcase

      if (w_go_len) begin
         w_ld_state_next   = LdLen;
         w_loading_next    = 1'b1;
         w_cpu_nreset_next = 1'b0;
         w_load_error_next = 1'b0;
      end
      if (w_go_err) begin
         w_ld_state_next   = LdErr;
         w_loading_next    = 1'b0;
         w_cpu_nreset_next = 1'b0;
         w_load_error_next = 1'b1;
      end
   end

   // Not cleared by nReset so a core reset keeps the loaded program.
   logic [7:0] r_mem [256];

   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         r_mem[r_addr] <= r_rx_shift;
      end
   end

   assign instruction = r_mem[pc];
   assign cpu_nReset  = r_cpu_nreset;
   assign loading     = r_loading;
   assign load_error  = r_load_error;

   // ------------------------------------------------------------ status echo
`ifdef HC4E_LOADER_ECHO_EN
   logic        r_status_req;
   logic [7:0]  r_status_byte;
   logic        r_tx_busy;
   logic        r_tx_line;
   logic [8:0]  r_tx_shift;
   logic [15:0] r_tx_cnt;
   logic [3:0]  r_tx_bitcnt;

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         r_status_req  <= 1'b0;
         r_status_byte <= '0;
      end else begin
         r_status_req <= 1'b0;
         if (r_ld_state == LdCsum && w_ld_state_next == LdIdle) begin
            r_status_req  <= 1'b1;
            r_status_byte <= 8'h06;
         end else if (r_ld_state != LdErr && w_ld_state_next == LdErr) begin
            r_status_req  <= 1'b1;
            r_status_byte <= 8'h15;
         end
      end
   end

   // Bit periods: start (0), data LSB first (1..8), stop (9). Busy drops new requests.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         r_tx_busy   <= 1'b0;
         r_tx_line   <= 1'b1;
         r_tx_shift  <= '1;
         r_tx_cnt    <= '0;
         r_tx_bitcnt <= '0;
      end else if (!r_tx_busy) begin
         if (r_status_req) begin
            r_tx_busy   <= 1'b1;
            r_tx_line   <= 1'b0;
            r_tx_shift  <= {1'b1, r_status_byte};
            r_tx_cnt    <= '0;
            r_tx_bitcnt <= '0;
         end
      end else if (r_tx_cnt == BitLast) begin
         r_tx_cnt <= '0;
         if (r_tx_bitcnt == 4'd9) begin
            r_tx_busy <= 1'b0;
            r_tx_line <= 1'b1;
         end else begin
            r_tx_line   <= r_tx_shift[0];
            r_tx_shift  <= {1'b1, r_tx_shift[8:1]};
            r_tx_bitcnt <= r_tx_bitcnt + 4'd1;
         end
      end else begin
         r_tx_cnt <= r_tx_cnt + 16'd1;
      end
   end

   assign uart_tx = r_tx_line;
`else
   assign uart_tx = 1'b1;
`endif

endmodule

// File: tb/tb_hc4e_prog_loader.sv
// Directed bench for hc4e_prog_loader: table of UART bytes with expected outputs,
// plus hand-written sequences for the 256-byte load, mid-load reset and start glitch.
module tb_hc4e_prog_loader;

   logic       clock = 1'b0;
   logic       nReset = 1'b0;
   logic       uart_rx = 1'b1;
   logic [7:0] pc = 8'd0;
   logic [7:0] instruction;
   logic       cpu_nReset;
   logic       loading;
   logic       load_error;
   logic       uart_tx;

   always #5 clock = ~clock;

   hc4e_prog_loader #(
      .CLK_HZ    (1_000_000),
      .BAUD      (100_000),
      .SYNC_BYTE (8'hA5)
   ) dut (
      .clock       (clock),
      .nReset      (nReset),
      .uart_rx     (uart_rx),
      .pc          (pc),
      .instruction (instruction),
      .cpu_nReset  (cpu_nReset),
      .loading     (loading),
      .load_error  (load_error),
      .uart_tx     (uart_tx)
   );

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       exp_ld;
      logic       exp_err;
      logic       exp_cpu;
      logic       chk_mem;
      logic [7:0] pc;
      logic [7:0] exp_ins;
   } vec_t;

   vec_t       vecs [22];
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] echo_q [$];
   logic [7:0] exp_echo [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One 8N1 frame at 10 clocks per bit, then one idle bit; starts and ends on a negedge.
   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (10) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (10) @(negedge clock);
      end
      uart_rx = stop;
      repeat (10) @(negedge clock);
      uart_rx = 1'b1;
      repeat (10) @(negedge clock);
   endtask

   task automatic check_status(input string tag, input logic ld, input logic err,
                               input logic cpu);
      check({tag, ".loading"}, loading, ld);
      check({tag, ".load_error"}, load_error, err);
      check({tag, ".cpu_nReset"}, cpu_nReset, cpu);
   endtask

   task automatic check_mem(input string tag, input logic [7:0] addr, input logic [7:0] exp);
      pc = addr;
      #1;
      check({tag, ".instruction"}, instruction, exp);
   endtask

   // Decodes frames appearing on uart_tx, sampling mid-bit.
   initial begin : tx_monitor
      logic [7:0] b;
      forever begin
         @(negedge uart_tx);
         repeat (5) @(negedge clock);
         for (int i = 0; i < 8; i++) begin
            repeat (10) @(negedge clock);
            b[i] = uart_tx;
         end
         repeat (10) @(negedge clock);
         echo_q.push_back(b);
      end
   end

   initial begin
      //            data   stop  ld    err   cpu   chk   pc     ins
      vecs[0]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[1]  = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[2]  = '{8'hE1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE1};
      vecs[3]  = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h12};
      vecs[4]  = '{8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h34};
      vecs[5]  = '{8'h27, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h12};
      vecs[6]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE1};
      vecs[7]  = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[8]  = '{8'hE1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE1};
      vecs[9]  = '{8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 8'h12};
      vecs[10] = '{8'h34, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 8'h34};
      vecs[11] = '{8'h28, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hE1};
      vecs[12] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'hE1};
      vecs[13] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[14] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h55};
      vecs[15] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h55};
      vecs[16] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h55};
      vecs[17] = '{8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h12};
      vecs[18] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h34};
      vecs[19] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[20] = '{8'h02, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[21] = '{8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h55};

      // Reset state, then release: cpu_nReset rises on the first edge only.
      repeat (3) @(negedge clock);
      check_status("rst", 1'b0, 1'b0, 1'b0);
      check("rst.uart_tx", uart_tx, 1'b1);
      nReset = 1'b1;
      #1;
      check("rel.cpu_nReset_pre_edge", cpu_nReset, 1'b0);
      @(negedge clock);
      check_status("rel", 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 22; i++) begin
         send_byte(vecs[i].data, vecs[i].stop);
         check_status($sformatf("v%0d", i), vecs[i].exp_ld, vecs[i].exp_err, vecs[i].exp_cpu);
`ifndef HC4E_LOADER_ECHO_EN
         check($sformatf("v%0d.uart_tx", i), uart_tx, 1'b1);
`endif
         if (vecs[i].chk_mem) begin
            check_mem($sformatf("v%0d", i), vecs[i].pc, vecs[i].exp_ins);
         end
      end

      // Full 256-byte image from the error state; length byte 0 means 256.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'(i), 1'b1);
      end
      check_status("full.pre_csum", 1'b1, 1'b0, 1'b0);
      send_byte(8'h80, 1'b1);
      check_status("full.done", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 256; i++) begin
         check_mem($sformatf("full.mem%0d", i), 8'(i), 8'(i));
      end

      // nReset in the middle of DATA; memory survives, loader restarts in IDLE.
      send_byte(8'hA5, 1'b1);
      send_byte(8'h05, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      check_status("mid.before", 1'b1, 1'b0, 1'b0);
      #2;
      nReset = 1'b0;
      #1;
      check_status("mid.in_reset", 1'b0, 1'b0, 1'b0);
      check("mid.uart_tx", uart_tx, 1'b1);
      @(negedge clock);
      nReset = 1'b1;
      @(negedge clock);
      check_status("mid.released", 1'b0, 1'b0, 1'b1);
      check_mem("mid.keep0", 8'h00, 8'h11);
      check_mem("mid.keep1", 8'h01, 8'h22);
      send_byte(8'h33, 1'b1);
      check_status("mid.idle_byte", 1'b0, 1'b0, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h77, 1'b1);
      send_byte(8'h77, 1'b1);
      check_status("mid.reload", 1'b0, 1'b0, 1'b1);
      check_mem("mid.reload", 8'h00, 8'h77);

      // A short low pulse must not be taken as a start bit.
      uart_rx = 1'b0;
      repeat (3) @(negedge clock);
      uart_rx = 1'b1;
      repeat (50) @(negedge clock);
      check_status("glitch.idle", 1'b0, 1'b0, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h66, 1'b1);
      send_byte(8'h66, 1'b1);
      check_status("glitch.load", 1'b0, 1'b0, 1'b1);
      check_mem("glitch.load", 8'h00, 8'h66);

      repeat (300) @(negedge clock);
`ifdef HC4E_LOADER_ECHO_EN
      exp_echo = '{8'h06, 8'h15, 8'h06, 8'h15, 8'h06, 8'h06, 8'h06};
`endif
      check("echo.count", echo_q.size(), exp_echo.size());
      foreach (exp_echo[i]) begin
         if (i < echo_q.size()) begin
            check($sformatf("echo.frame%0d", i), echo_q[i], exp_echo[i]);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hc4e_prog_loader.md
Name: hc4e_prog_loader

Overview:
Program-memory stage directly upstream of the HC4e core. It holds 256x8 instruction memory, read combinationally at the core's PC to drive its instruction input. A serial UART loader writes new programs into that memory. While a load is in progress, the loader holds the core in reset through cpu_nReset.

Parameters:
CLK_HZ, 20_000_000, frequency of clock in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer division
SYNC_BYTE, 8'hA5, byte that starts a load

Ports:
clock  input  1  system clock
nReset  input  1  asynchronous, active-low reset
uart_rx  input  1  serial input, 8N1, idle high, asynchronous to clock
pc  input  8  core program counter; read address
instruction  output  8  mem[pc], combinational
cpu_nReset  output  1  active-low reset to core; low while loading or in error
loading  output  1  high from SYNC accepted until checksum judged
load_error  output  1  high after a bad checksum or framing error; cleared by next SYNC
uart_tx  output  1  status echo, see Optional Feature; constant 1 when feature absent

Behaviour:
- Interface: reset nReset, asynchronous, active-low; clock clock.
- nReset low: FSM=IDLE, loading=0, load_error=0, cpu_nReset=0, uart_tx=1, address and checksum counters=0, RX FSM idle.
- Release of nReset: cpu_nReset goes 1 on the first clock edge after release.
- Memory is not cleared by reset. Power-up contents are all 8'h00.
- instruction = mem[pc] at all times, including during a load. There is no clock latency on the read.
- uart_rx path: 2-FF synchronizer, then RX FSM with states R_IDLE, R_START, R_DATA, R_STOP.
  - Falling edge starts R_START. Sample at CLKS_PER_BIT/2. If the line is high there, treat it as a glitch and return to R_IDLE.
  - Take 8 data samples, LSB first, one per CLKS_PER_BIT.
  - Sample the stop bit mid-bit. If it is 1, pulse rx_valid for 1 cycle with the byte. If it is 0, pulse rx_ferr for 1 cycle and discard the byte.
- Loader FSM states: IDLE, LEN, DATA, CSUM, ERR.
  - IDLE: cpu_nReset=1. A byte equal to SYNC_BYTE moves to LEN; on that edge loading=1, cpu_nReset=0, load_error=0. Other bytes and rx_ferr are ignored.
  - LEN: store N = byte, where 0 means 256. Clear addr=0 and sum=0. Go to DATA.
  - DATA: each byte writes mem[addr] on the rx_valid cycle. Then addr += 1 (8-bit wrap) and sum = (sum + byte) mod 256. After N bytes go to CSUM.
  - CSUM: a byte equal to sum goes to IDLE; loading=0 and cpu_nReset=1 on the next edge. A mismatch goes to ERR.
  - ERR: loading=0, load_error=1, cpu_nReset=0. Only a SYNC_BYTE leaves ERR, moving to LEN as from IDLE. Other bytes are ignored.
  - rx_ferr in LEN, DATA or CSUM: go to ERR immediately. Bytes already written stay in memory.
- There is no inter-byte timeout. A stalled load waits indefinitely with the core held in reset.
- The core reads its instruction combinationally with no fetch handshake. The core's own slow clock is not controlled here.

Optional Feature:
Macro HC4E_LOADER_ECHO_EN.
- Defined:
  - Adds an 8N1 UART transmitter at BAUD on uart_tx.
  - Sends 8'h06 (ACK) one cycle after a good checksum.
  - Sends 8'h15 (NAK) one cycle after entering ERR.
  - If a new status arrives while a byte is still transmitting, the new status is dropped.
  - uart_tx idles at 1.
- Undefined: no transmitter logic is built and uart_tx is tied to 1.

Test Plan:
- CLK_HZ=1_000_000, BAUD=100_000. Send A5, 03, E1, 12, 34, 27 (checksum 0x27) -> mem[0..2]=E1,12,34; loading high from the A5 stop bit until the 27 stop bit; then cpu_nReset=1, load_error=0; pc=1 gives instruction=12.
- Same stream with last byte 28 -> ERR; load_error=1, cpu_nReset stays 0; mem[0..2] still written. Then send A5, 01, 55, 55 -> load_error=0, cpu_nReset=1, mem[0]=55.
- In IDLE send 00, 7F, FF -> no state change; cpu_nReset stays 1 and memory is unchanged.
- A5, 02, then a byte with stop bit forced low -> ERR on that frame; load_error=1; mem[0] unchanged.
- A5, 00, then 256 bytes of value i (i=0..255), then checksum 80 -> all 256 locations hold i; addr wraps to 0; cpu_nReset=1.
- Assert nReset low mid-DATA -> cpu_nReset=0 and loading=0 immediately; after release the FSM is in IDLE and cpu_nReset=1. With HC4E_LOADER_ECHO_EN defined, check uart_tx carries frames 06 and 15 in the first two scenarios.
